// File: rtl/armleocpu_plic_scan_arbiter_if.sv
// Claim/complete handshake between the PLIC register block (master)
// and the arbitration core (slave).
interface armleocpu_plic_scan_arbiter_if #(
  parameter int CW  = 2,
  parameter int IDW = 6
);
  logic           claim_valid;
  logic [CW-1:0]  claim_context;
  logic           claim_ready;
  logic [IDW-1:0] claim_id;
  logic           complete_valid;
  logic [IDW-1:0] complete_id;

  modport master (
    output claim_valid, claim_context, complete_valid, complete_id,
    input  claim_ready, claim_id
  );

  modport slave (
    input  claim_valid, claim_context, complete_valid, complete_id,
    output claim_ready, claim_id
  );
endinterface

// File: rtl/armleocpu_plic_scan_arbiter.sv
// PLIC arbitration core: per-source gateway state (pending/in_service),
// one priority comparator time-shared across all contexts by a serial
// source scan, and claim/complete servicing.
// Optional: define PLIC_EDGE_TRIGGER_EN for an edge-triggered gateway;
// the default build uses a level-sensitive gateway.
module armleocpu_plic_scan_arbiter #(
  parameter int CONTEXT_COUNT          = 4,
  parameter int INTERRUPT_SOURCE_COUNT = 32,
  parameter int PRIORITY_WIDTH         = 3,
  localparam int CW  = (CONTEXT_COUNT > 1) ? $clog2(CONTEXT_COUNT) : 1,
  localparam int IDW = $clog2(INTERRUPT_SOURCE_COUNT + 1)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [INTERRUPT_SOURCE_COUNT-1:0]            irq_in,
  input  logic [INTERRUPT_SOURCE_COUNT*PRIORITY_WIDTH-1:0] prio_flat,
  input  logic [CONTEXT_COUNT*INTERRUPT_SOURCE_COUNT-1:0]  enable_flat,
  input  logic [CONTEXT_COUNT*PRIORITY_WIDTH-1:0]      threshold_flat,
  armleocpu_plic_scan_arbiter_if.slave                 claim_bus,
  output logic [CONTEXT_COUNT-1:0]                     context_irq,
  output logic [CONTEXT_COUNT*IDW-1:0]                 context_best_id
);
  localparam int N  = INTERRUPT_SOURCE_COUNT;
  localparam int PW = PRIORITY_WIDTH;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {SCAN, COMMIT} state_t;
  state_t state, state_nxt;
  logic   scan_en, commit_en;

  logic [N-1:0]   pending, in_service, gw_set, claim_mask, complete_mask;
  logic [SW-1:0]  src;
  logic [CW-1:0]  ctx;
  logic [PW-1:0]  best_prio;
  logic [IDW-1:0] best_id;
  logic [IDW-1:0] best_id_q [CONTEXT_COUNT];
  logic [IDW-1:0] bid_nxt [CONTEXT_COUNT];
  logic [CONTEXT_COUNT-1:0] irq_nxt;

  logic [PW-1:0]  prio [N];
  logic [N-1:0]   en [CONTEXT_COUNT];
  logic [PW-1:0]  thr [CONTEXT_COUNT];

  logic [PW-1:0]  cur_prio, cur_thr;
  logic           cur_pend, cur_en, candidate, best_pend, commit_hit, commit_irq;
  logic [IDW-1:0] commit_id, claim_best;
  logic [N-1:0]   claim_row;
  logic           claim_ok;

  // Unpack the flat configuration buses into per-source / per-context views.
  always_comb begin
    for (int i = 0; i < N; i++) prio[i] = prio_flat[i*PW +: PW];
    for (int c = 0; c < CONTEXT_COUNT; c++) begin
      en[c]  = enable_flat[c*N +: N];
      thr[c] = threshold_flat[c*PW +: PW];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SCAN;
    else        state <= state_nxt;
  end

  // FSM next state: scan every source of a context, then one commit cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:    if (src == SW'(N - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = SCAN;
      default: state_nxt = SCAN;
    endcase
  end

  // FSM outputs.
  always_comb begin
    scan_en   = (state == SCAN);
    commit_en = (state == COMMIT);
  end

  // Comparator operands for the current (ctx, src) pair and the commit recheck.
  always_comb begin
    cur_prio  = prio[src];
    cur_pend  = pending[src];
    cur_en    = 1'b0;
    cur_thr   = '0;
    best_pend = 1'b0;
    for (int c = 0; c < CONTEXT_COUNT; c++) begin
      if (ctx == CW'(c)) begin
        cur_en  = en[c][src];
        cur_thr = thr[c];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (best_id == IDW'(i + 1)) best_pend = pending[i];
    end
    // Strict compare: on equal priority the earlier (lower id) source is kept.
    candidate  = cur_pend && cur_en && (cur_prio != '0) && (cur_prio > best_prio);
    commit_hit = (best_id != '0) && best_pend;
    commit_id  = commit_hit ? best_id : '0;
    commit_irq = commit_hit && (best_prio > cur_thr);
  end

  // Claim and complete decode into one-hot source masks.
  always_comb begin
    claim_best    = '0;
    claim_row     = '0;
    claim_mask    = '0;
    complete_mask = '0;
    for (int c = 0; c < CONTEXT_COUNT; c++) begin
      if (claim_bus.claim_context == CW'(c)) begin
        claim_best = best_id_q[c];
        claim_row  = en[c];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (claim_bus.claim_valid && (claim_best == IDW'(i + 1)) && pending[i] && claim_row[i])
        claim_mask[i] = 1'b1;
      if (claim_bus.complete_valid && (claim_bus.complete_id == IDW'(i + 1)) && in_service[i])
        complete_mask[i] = 1'b1;
    end
    claim_ok = |claim_mask;
  end

`ifdef PLIC_EDGE_TRIGGER_EN
  logic [N-1:0] irq_prev;

  // Delay the request lines by one cycle for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_prev <= '0;
    else        irq_prev <= irq_in;
  end

  assign gw_set = irq_in & ~irq_prev & ~in_service;
`else
  assign gw_set = irq_in & ~pending & ~in_service;
`endif

  // Per-context results: commit first, then a successful claim scrubs its id
  // everywhere (including a value committed this same cycle).
  always_comb begin
    for (int c = 0; c < CONTEXT_COUNT; c++) begin
      bid_nxt[c] = best_id_q[c];
      irq_nxt[c] = context_irq[c];
      if (commit_en && (ctx == CW'(c))) begin
        bid_nxt[c] = commit_id;
        irq_nxt[c] = commit_irq;
      end
      if (claim_ok && (bid_nxt[c] == claim_best)) begin
        bid_nxt[c] = '0;
        irq_nxt[c] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < CONTEXT_COUNT; g++) begin : g_best_out
    assign context_best_id[g*IDW +: IDW] = best_id_q[g];
  end

  // Gateway state: a claim clears pending and wins over a same-cycle complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      in_service <= '0;
    end else begin
      pending    <= (pending | gw_set) & ~claim_mask;
      in_service <= (in_service & ~complete_mask) | claim_mask;
    end
  end

  // Published per-context best id and irq line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      context_irq <= '0;
      for (int c = 0; c < CONTEXT_COUNT; c++) best_id_q[c] <= '0;
    end else begin
      context_irq <= irq_nxt;
      for (int c = 0; c < CONTEXT_COUNT; c++) best_id_q[c] <= bid_nxt[c];
    end
  end

  // Registered claim response, one strobe per request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      claim_bus.claim_ready <= 1'b0;
      claim_bus.claim_id    <= '0;
    end else begin
      claim_bus.claim_ready <= claim_bus.claim_valid;
      claim_bus.claim_id    <= claim_ok ? claim_best : '0;
    end
  end

  // Scan pointers and running best for the context under evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src       <= '0;
      ctx       <= '0;
      best_prio <= '0;
      best_id   <= '0;
    end else if (scan_en) begin
      if (candidate) begin
        best_prio <= cur_prio;
        best_id   <= IDW'(src) + IDW'(1);
      end
      if (src != SW'(N - 1)) src <= src + SW'(1);
    end else begin
      best_prio <= '0;
      best_id   <= '0;
      src       <= '0;
      ctx       <= (ctx == CW'(CONTEXT_COUNT - 1)) ? '0 : ctx + CW'(1);
    end
  end
endmodule

// File: tb/tb_armleocpu_plic_scan_arbiter.sv
// Directed bench for armleocpu_plic_scan_arbiter (both gateway modes,
// selected by PLIC_EDGE_TRIGGER_EN).
module tb_armleocpu_plic_scan_arbiter;
  localparam int CC    = 4;
  localparam int N     = 32;
  localparam int PW    = 3;
  localparam int CW    = 2;
  localparam int IDW   = 6;
  localparam int SWEEP = CC * (N + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0]     irq_in;
  logic [N*PW-1:0]  prio_flat;
  logic [CC*N-1:0]  enable_flat;
  logic [CC*PW-1:0] threshold_flat;
  logic [CC-1:0]    context_irq;
  logic [CC*IDW-1:0] context_best_id;

  int tests = 0;
  int fails = 0;

  armleocpu_plic_scan_arbiter_if #(.CW(CW), .IDW(IDW)) bus ();

  armleocpu_plic_scan_arbiter #(
    .CONTEXT_COUNT(CC), .INTERRUPT_SOURCE_COUNT(N), .PRIORITY_WIDTH(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .prio_flat(prio_flat),
    .enable_flat(enable_flat), .threshold_flat(threshold_flat),
    .claim_bus(bus), .context_irq(context_irq), .context_best_id(context_best_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [IDW-1:0] best(input int c);
    return context_best_id[c*IDW +: IDW];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_best(input int c, input logic [IDW-1:0] id, input int limit);
    for (int k = 0; k < limit && best(c) !== id; k++) tick();
  endtask

  initial begin
    irq_in = '0; prio_flat = '0; enable_flat = '0; threshold_flat = '0;
    bus.claim_valid = 1'b0; bus.claim_context = '0;
    bus.complete_valid = 1'b0; bus.complete_id = '0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_irq", 32'(context_irq), 0);
    check("rst_best", 32'(context_best_id), 0);
    check("rst_ready", 32'(bus.claim_ready), 0);
    check("rst_claim_id", 32'(bus.claim_id), 0);
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Single source reaches context 0 only
    irq_in[4] = 1'b1;
    prio_flat[4*PW +: PW] = 3'd3;
    enable_flat[0*N + 4] = 1'b1;
    wait_best(0, 6'd5, 2*(N+1)+2);
    check("t1_best0", 32'(best(0)), 5);
    check("t1_irq0", 32'(context_irq[0]), 1);
    check("t1_best_others", 32'(context_best_id[CC*IDW-1:IDW]), 0);
    check("t1_irq_others", 32'(context_irq[CC-1:1]), 0);

    // Equal priority tie goes to the lowest id; threshold is strict
    irq_in[2] = 1'b1; irq_in[7] = 1'b1;
    prio_flat[2*PW +: PW] = 3'd5; prio_flat[7*PW +: PW] = 3'd5;
    enable_flat[1*N + 2] = 1'b1; enable_flat[1*N + 7] = 1'b1;
    threshold_flat[1*PW +: PW] = 3'd5;
    wait_cycles(2*SWEEP);
    check("t2_best1", 32'(best(1)), 3);
    check("t2_irq1_thr5", 32'(context_irq[1]), 0);
    check("t2_best0_kept", 32'(best(0)), 5);
    threshold_flat[1*PW +: PW] = 3'd4;
    wait_cycles(2*SWEEP);
    check("t2_irq1_thr4", 32'(context_irq[1]), 1);
    check("t2_best1_again", 32'(best(1)), 3);

    // Shared id across contexts: one claim scrubs both, second claim gets 0
    enable_flat[2*N + 4] = 1'b1;
    wait_cycles(2*SWEEP);
    check("t3_best2", 32'(best(2)), 5);
    check("t3_irq2", 32'(context_irq[2]), 1);
    bus.claim_valid = 1'b1; bus.claim_context = 2'd0;
    tick();
    check("t3_ready", 32'(bus.claim_ready), 1);
    check("t3_claim_id", 32'(bus.claim_id), 5);
    check("t3_irq0_drop", 32'(context_irq[0]), 0);
    check("t3_irq2_drop", 32'(context_irq[2]), 0);
    check("t3_best0_zero", 32'(best(0)), 0);
    check("t3_best2_zero", 32'(best(2)), 0);
    check("t3_irq1_kept", 32'(context_irq[1]), 1);
    bus.claim_context = 2'd2;
    tick();
    check("t3_ready_b2b", 32'(bus.claim_ready), 1);
    check("t3_claim_id_dup", 32'(bus.claim_id), 0);
    bus.claim_valid = 1'b0;
    tick();
    check("t3_ready_low", 32'(bus.claim_ready), 0);
    check("t3_in_service", 32'(dut.in_service[4]), 1);
    check("t3_pending_clr", 32'(dut.pending[4]), 0);

    // In-service blocks re-pend; bad completes are ignored
    wait_cycles(2*SWEEP);
    check("t4_best0_held", 32'(best(0)), 0);
    check("t4_irq0_held", 32'(context_irq[0]), 0);
    bus.complete_valid = 1'b1; bus.complete_id = 6'd0;
    tick();
    bus.complete_id = 6'd40;
    tick();
    bus.complete_valid = 1'b0;
    tick();
    check("t4_bad_complete", 32'(dut.in_service[4]), 1);
    bus.complete_valid = 1'b1; bus.complete_id = 6'd5;
    tick();
    bus.complete_valid = 1'b0;
    check("t4_complete", 32'(dut.in_service[4]), 0);
    check("t4_pending_gap", 32'(dut.pending[4]), 0);
    tick();
`ifdef PLIC_EDGE_TRIGGER_EN
    check("t4_no_edge", 32'(dut.pending[4]), 0);
    irq_in[4] = 1'b0;
    tick();
    irq_in[4] = 1'b1;
    tick();
`endif
    check("t4_repend", 32'(dut.pending[4]), 1);
    wait_cycles(2*SWEEP);
    check("t4_best0_back", 32'(best(0)), 5);

    // Claim and complete of the same id in one cycle: claim wins
    bus.claim_valid = 1'b1; bus.claim_context = 2'd0;
    bus.complete_valid = 1'b1; bus.complete_id = 6'd5;
    tick();
    bus.claim_valid = 1'b0; bus.complete_valid = 1'b0;
    check("t5_claim_id", 32'(bus.claim_id), 5);
    check("t5_in_service", 32'(dut.in_service[4]), 1);
    check("t5_pending", 32'(dut.pending[4]), 0);
    tick();
    bus.complete_valid = 1'b1; bus.complete_id = 6'd5;
    tick();
    bus.complete_valid = 1'b0;
    check("t5_complete", 32'(dut.in_service[4]), 0);

`ifdef PLIC_EDGE_TRIGGER_EN
    // Held-high line produces one interrupt; a fresh edge produces another
    irq_in[0] = 1'b1;
    prio_flat[0*PW +: PW] = 3'd2;
    enable_flat[3*N + 0] = 1'b1;
    wait_cycles(2*SWEEP);
    check("e_best3", 32'(best(3)), 1);
    check("e_irq3", 32'(context_irq[3]), 1);
    bus.claim_valid = 1'b1; bus.claim_context = 2'd3;
    tick();
    bus.claim_valid = 1'b0;
    check("e_claim1", 32'(bus.claim_id), 1);
    bus.complete_valid = 1'b1; bus.complete_id = 6'd1;
    tick();
    bus.complete_valid = 1'b0;
    wait_cycles(2*SWEEP);
    check("e_no_repend", 32'(best(3)), 0);
    irq_in[0] = 1'b0;
    tick();
    irq_in[0] = 1'b1;
    wait_cycles(2*SWEEP);
    check("e_best3_edge", 32'(best(3)), 1);
    bus.claim_valid = 1'b1; bus.claim_context = 2'd3;
    tick();
    bus.claim_valid = 1'b0;
    check("e_claim2", 32'(bus.claim_id), 1);
`endif

    // Reset in the middle of a claim
    wait_cycles(2*SWEEP);
    bus.claim_valid = 1'b1; bus.claim_context = 2'd1;
    #2 rst_n = 1'b0;
    #1;
    check("r_ready", 32'(bus.claim_ready), 0);
    check("r_irq", 32'(context_irq), 0);
    check("r_best", 32'(context_best_id), 0);
    check("r_pending", 32'(dut.pending), 0);
    @(negedge clk);
    bus.claim_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("r_no_response", 32'(bus.claim_ready), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
